operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Register-fetch/forwarding stage that consumes the writeback and forwarding-tap outputs of the even and odd execution pipes.
- Holds the 128 x 128-bit register file, written from both pipes' WB ports.
- For each issued instruction pair, resolves ra/rb/rc for both slots from the youngest in-flight producer (forwarding taps), then the WB ports, then the register file.
- Registers the resolved operands one cycle into the execute stage of both pipes.

Parameters:
- NUM_REGS, 128, register file depth (address 7 bits).
- WIDTH, 128, register and operand width.
- FW_DEPTH, 7, forwarding taps per pipe, indices 0..6.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  instruction pair present in RF stage
- stall  in  1  hold output registers (RAW stall from pipes)
- flush  in  1  branch_taken; kill pair in RF stage
- ra_even_addr, rb_even_addr, rc_even_addr  in  7 each  even-slot source addresses
- ra_odd_addr, rb_odd_addr, rc_odd_addr  in  7 each  odd-slot source addresses
- is_ra_even_valid, is_rb_even_valid, is_rc_even_valid  in  1 each  even source used
- is_ra_odd_valid, is_rb_odd_valid, is_rc_odd_valid  in  1 each  odd source used
- even_fw_wb, odd_fw_wb  in  7x128 each  forwarding tap values, index 0..6
- even_fw_addr_wb, odd_fw_addr_wb  in  7x7 each  tap destination addresses
- even_fw_write_wb, odd_fw_write_wb  in  7 each  tap write-valid flags
- even_rt_wb, odd_rt_wb  in  128 each  WB data
- even_rt_addr_wb, odd_rt_addr_wb  in  7 each  WB address
- even_reg_write_wb, odd_reg_write_wb  in  1 each  WB enable
- ra_even, rb_even, rc_even, ra_odd, rb_odd, rc_odd  out  128 each  resolved operands, registered
- operands_valid  out  1  outputs hold a live pair

Behaviour:
- Reset (sync, active-high): all registers in the file cleared to 0; all operand outputs 0; operands_valid 0. Reset mid-stall or mid-flush: reset wins.
- Register file write at posedge when a reg_write_wb is high.
  - Both ports target the same address in the same cycle: odd value written.
  - Writes are suppressed during reset.
- Combinational resolution per operand, first match wins:
  1. Tap index k = 1..6 ascending, lower index is younger. At equal k the odd tap beats the even tap. A match needs fw_write_wb[k]=1 and fw_addr_wb[k]=src addr.
  2. odd WB port, then even WB port (same-cycle write-through).
  3. Register file content.
- Tap index 0 is never used as a source.
- Source valid bit = 0: operand resolves to 0 regardless of address.
- Output register, latency 1 cycle from RF-stage inputs. Update priority:
  - flush=1: operands_valid <= 0, operands <= 0. Flush beats stall.
  - else stall=1: all outputs hold their previous values. The WB-port file write still occurs.
  - else: operands <= resolved values; operands_valid <= in_valid.
- in_valid=0 with no stall: operands still load resolved values (don't-care) and operands_valid <= 0.
- No internal state machine beyond the file and output register. Stall generation stays in the pipes.

Optional Feature:
- Macro OPFETCH_FWD_EN.
- Defined: full tap forwarding as in resolution step 1.
- Undefined: step 1 removed; tap ports remain but are ignored. Operands come from the WB ports or the file only, and the pipes must stall until the producer reaches WB.

Test Plan:
- Reset, then every operand address selected with all valids=1 -> all six outputs 0 and operands_valid=0 one cycle after reset deasserts.
- even WB writes r5=0xAAAA..., next cycle in_valid with ra_even_addr=5 -> ra_even=0xAAAA... one cycle later, operands_valid=1.
- even_fw tap 4 = (r9, 0x11..), odd_fw tap 2 = (r9, 0x22..), file r9=0x33.. -> rb_odd=0x22.. (youngest tap). With OPFETCH_FWD_EN undefined -> 0x33...
- Same tap index 3 on both pipes targets r12: even=0x1, odd=0x2 -> operand=0x2. Both WB ports write r12 simultaneously (even=0x5, odd=0x6) -> later read from file returns 0x6.
- Load pair A, assert stall 3 cycles while changing addresses -> outputs frozen at A's values; deassert -> new pair appears next cycle.
- stall=1 and flush=1 together -> operands_valid=0, outputs 0. is_rc_odd_valid=0 with rc_odd_addr matching a live tap -> rc_odd=0.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: 128x128 register file, WB write-through and tap forwarding, registered operands.
// Tap forwarding is compiled in only when OPFETCH_FWD_EN is defined.
module operand_fetch #(
  parameter int NUM_REGS = 128,
  parameter int WIDTH    = 128,
  parameter int FW_DEPTH = 7
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic                               stall,
  input  logic                               flush,
  input  logic [6:0]                         ra_even_addr,
  input  logic [6:0]                         rb_even_addr,
  input  logic [6:0]                         rc_even_addr,
  input  logic [6:0]                         ra_odd_addr,
  input  logic [6:0]                         rb_odd_addr,
  input  logic [6:0]                         rc_odd_addr,
  input  logic                               is_ra_even_valid,
  input  logic                               is_rb_even_valid,
  input  logic                               is_rc_even_valid,
  input  logic                               is_ra_odd_valid,
  input  logic                               is_rb_odd_valid,
  input  logic                               is_rc_odd_valid,
  input  logic [FW_DEPTH-1:0][WIDTH-1:0]     even_fw_wb,
  input  logic [FW_DEPTH-1:0][WIDTH-1:0]     odd_fw_wb,
  input  logic [FW_DEPTH-1:0][6:0]           even_fw_addr_wb,
  input  logic [FW_DEPTH-1:0][6:0]           odd_fw_addr_wb,
  input  logic [FW_DEPTH-1:0]                even_fw_write_wb,
  input  logic [FW_DEPTH-1:0]                odd_fw_write_wb,
  input  logic [WIDTH-1:0]                   even_rt_wb,
  input  logic [WIDTH-1:0]                   odd_rt_wb,
  input  logic [6:0]                         even_rt_addr_wb,
  input  logic [6:0]                         odd_rt_addr_wb,
  input  logic                               even_reg_write_wb,
  input  logic                               odd_reg_write_wb,
  output logic [WIDTH-1:0]                   ra_even,
  output logic [WIDTH-1:0]                   rb_even,
  output logic [WIDTH-1:0]                   rc_even,
  output logic [WIDTH-1:0]                   ra_odd,
  output logic [WIDTH-1:0]                   rb_odd,
  output logic [WIDTH-1:0]                   rc_odd,
  output logic                               operands_valid
);

  logic [WIDTH-1:0] rf [NUM_REGS];
  logic [6:0]       src_addr [6];
  logic             src_vld  [6];
  logic [WIDTH-1:0] resolved [6];
  logic [WIDTH-1:0] ops_q    [6];
  logic             valid_q;

  // Slot order: ra/rb/rc even, then ra/rb/rc odd.
  assign src_addr[0] = ra_even_addr;
  assign src_addr[1] = rb_even_addr;
  assign src_addr[2] = rc_even_addr;
  assign src_addr[3] = ra_odd_addr;
  assign src_addr[4] = rb_odd_addr;
  assign src_addr[5] = rc_odd_addr;
  assign src_vld[0]  = is_ra_even_valid;
  assign src_vld[1]  = is_rb_even_valid;
  assign src_vld[2]  = is_rc_even_valid;
  assign src_vld[3]  = is_ra_odd_valid;
  assign src_vld[4]  = is_rb_odd_valid;
  assign src_vld[5]  = is_rc_odd_valid;

`ifdef OPFETCH_FWD_EN
  // Tap 0 is the pipe's own stage-0 result and is never a forwarding source.
  logic unused_tap0;
  assign unused_tap0 = ^{even_fw_wb[0], odd_fw_wb[0], even_fw_addr_wb[0],
                         odd_fw_addr_wb[0], even_fw_write_wb[0], odd_fw_write_wb[0]};
`else
  logic unused_taps;
  assign unused_taps = ^{even_fw_wb, odd_fw_wb, even_fw_addr_wb,
                         odd_fw_addr_wb, even_fw_write_wb, odd_fw_write_wb};
`endif

  // Lowest priority source applied first; later assignments override, so the
  // youngest tap (smallest k, odd over even) ends up winning.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      resolved[i] = rf[src_addr[i]];
      if (even_reg_write_wb && (even_rt_addr_wb == src_addr[i])) resolved[i] = even_rt_wb;
      if (odd_reg_write_wb && (odd_rt_addr_wb == src_addr[i]))   resolved[i] = odd_rt_wb;
`ifdef OPFETCH_FWD_EN
      for (int k = FW_DEPTH - 1; k >= 1; k--) begin
        if (even_fw_write_wb[k] && (even_fw_addr_wb[k] == src_addr[i])) resolved[i] = even_fw_wb[k];
        if (odd_fw_write_wb[k] && (odd_fw_addr_wb[k] == src_addr[i]))   resolved[i] = odd_fw_wb[k];
      end
`endif
      if (!src_vld[i]) resolved[i] = '0;
    end
  end

  // Odd port is written second so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
    end else begin
      if (even_reg_write_wb) rf[even_rt_addr_wb] <= even_rt_wb;
      if (odd_reg_write_wb)  rf[odd_rt_addr_wb]  <= odd_rt_wb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < 6; i++) ops_q[i] <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      for (int i = 0; i < 6; i++) ops_q[i] <= resolved[i];
      valid_q <= in_valid;
    end
  end

  assign ra_even        = ops_q[0];
  assign rb_even        = ops_q[1];
  assign rc_even        = ops_q[2];
  assign ra_odd         = ops_q[3];
  assign rb_odd         = ops_q[4];
  assign rc_odd         = ops_q[5];
  assign operands_valid = valid_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios then randomized traffic against a reference model.
module tb_operand_fetch;
  localparam int W = 128;
  localparam int N = 128;
  localparam int D = 7;
`ifdef OPFETCH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, in_valid, stall, flush;
  logic [6:0] sa [6];
  logic       sv [6];
  logic [D-1:0][W-1:0] efw, ofw;
  logic [D-1:0][6:0]   efa, ofa;
  logic [D-1:0]        efe, ofe;
  logic [W-1:0] ert, ort;
  logic [6:0]   era, ora;
  logic         ewe, owe;
  logic [W-1:0] ra_even, rb_even, rc_even, ra_odd, rb_odd, rc_odd;
  logic         operands_valid;

  logic [W-1:0] m_rf  [N];
  logic [W-1:0] m_out [6];
  logic         m_valid;
  logic [6*W-1:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .ra_even_addr(sa[0]), .rb_even_addr(sa[1]), .rc_even_addr(sa[2]),
    .ra_odd_addr(sa[3]), .rb_odd_addr(sa[4]), .rc_odd_addr(sa[5]),
    .is_ra_even_valid(sv[0]), .is_rb_even_valid(sv[1]), .is_rc_even_valid(sv[2]),
    .is_ra_odd_valid(sv[3]), .is_rb_odd_valid(sv[4]), .is_rc_odd_valid(sv[5]),
    .even_fw_wb(efw), .odd_fw_wb(ofw), .even_fw_addr_wb(efa), .odd_fw_addr_wb(ofa),
    .even_fw_write_wb(efe), .odd_fw_write_wb(ofe),
    .even_rt_wb(ert), .odd_rt_wb(ort), .even_rt_addr_wb(era), .odd_rt_addr_wb(ora),
    .even_reg_write_wb(ewe), .odd_reg_write_wb(owe),
    .ra_even(ra_even), .rb_even(rb_even), .rc_even(rc_even),
    .ra_odd(ra_odd), .rb_odd(rb_odd), .rc_odd(rc_odd),
    .operands_valid(operands_valid)
  );

  function automatic logic [W-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // First-match search in priority order: taps 1..6 (odd before even), WB odd, WB even, file.
  function automatic logic [W-1:0] model_resolve(int i);
    if (!sv[i]) return '0;
    if (FWD) begin
      for (int k = 1; k < D; k++) begin
        if (ofe[k] && ofa[k] == sa[i]) return ofw[k];
        if (efe[k] && efa[k] == sa[i]) return efw[k];
      end
    end
    if (owe && ora == sa[i]) return ort;
    if (ewe && era == sa[i]) return ert;
    return m_rf[sa[i]];
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic clear_taps();
    efw = '0; ofw = '0; efa = '0; ofa = '0; efe = '0; ofe = '0;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 6; i++) begin sa[i] = '0; sv[i] = 1'b0; end
    clear_taps();
    ert = '0; ort = '0; era = '0; ora = '0; ewe = 1'b0; owe = 1'b0;
  endtask

  // Advance the model by one clock with the currently driven inputs, then clock the DUT.
  task automatic cycle();
    logic [W-1:0] r [6];
    for (int i = 0; i < 6; i++) r[i] = model_resolve(i);
    if (reset) begin
      for (int a = 0; a < N; a++) m_rf[a] = '0;
      for (int i = 0; i < 6; i++) m_out[i] = '0;
      m_valid = 1'b0;
    end else begin
      if (flush) begin
        for (int i = 0; i < 6; i++) m_out[i] = '0;
        m_valid = 1'b0;
      end else if (!stall) begin
        for (int i = 0; i < 6; i++) m_out[i] = r[i];
        m_valid = in_valid;
      end
      if (ewe) m_rf[era] = ert;
      if (owe) m_rf[ora] = ort;
    end
    if (m_valid) exp_q.push_back({m_out[5], m_out[4], m_out[3], m_out[2], m_out[1], m_out[0]});
    @(posedge clk);
    #1;
  endtask

  // Monitor: every live output pair is matched against the next expected entry.
  initial begin
    logic [6*W-1:0] e;
    logic [W-1:0] got [6];
    string nm [6];
    nm = '{"ra_even", "rb_even", "rc_even", "ra_odd", "rb_odd", "rc_odd"};
    forever begin
      @(posedge clk);
      #1;
      if (operands_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_spurious_valid got=1 exp=0");
        end else begin
          e = exp_q.pop_front();
          got = '{ra_even, rb_even, rc_even, ra_odd, rb_odd, rc_odd};
          for (int i = 0; i < 6; i++) check({"sb_", nm[i]}, got[i], e[i*W +: W]);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] a [6];
    clear_inputs();
    // Reset with every source selected and live
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin sa[i] = 7'(i + 1); sv[i] = 1'b1; end
    cycle(); cycle();
    check("rst_ra_even", ra_even, '0);
    check("rst_rb_even", rb_even, '0);
    check("rst_rc_even", rc_even, '0);
    check("rst_ra_odd", ra_odd, '0);
    check("rst_rb_odd", rb_odd, '0);
    check("rst_rc_odd", rc_odd, '0);
    check("rst_valid", W'(operands_valid), '0);
    reset = 1'b0;
    cycle();
    check("post_rst_valid", W'(operands_valid), '0);
    check("post_rst_rc_odd", rc_odd, '0);

    // Even WB to r5, read back next cycle
    ewe = 1'b1; era = 7'd5; ert = {4{32'hAAAAAAAA}};
    cycle();
    ewe = 1'b0; in_valid = 1'b1; sa[0] = 7'd5;
    cycle();
    check("wb_r5_ra_even", ra_even, {4{32'hAAAAAAAA}});
    check("wb_r5_valid", W'(operands_valid), W'(1));

    // Youngest tap wins for r9
    owe = 1'b1; ora = 7'd9; ort = {16{8'h33}}; in_valid = 1'b0;
    cycle();
    owe = 1'b0;
    efe[4] = 1'b1; efa[4] = 7'd9; efw[4] = {16{8'h11}};
    ofe[2] = 1'b1; ofa[2] = 7'd9; ofw[2] = {16{8'h22}};
    sa[4] = 7'd9; in_valid = 1'b1;
    cycle();
    check("tap_young_rb_odd", rb_odd, FWD ? {16{8'h22}} : {16{8'h33}});
    clear_taps();

    // Same tap index on both pipes and both WB ports targeting r12
    efe[3] = 1'b1; efa[3] = 7'd12; efw[3] = W'(1);
    ofe[3] = 1'b1; ofa[3] = 7'd12; ofw[3] = W'(2);
    ewe = 1'b1; era = 7'd12; ert = W'(5);
    owe = 1'b1; ora = 7'd12; ort = W'(6);
    sa[1] = 7'd12;
    cycle();
    check("tap_tie_rb_even", rb_even, FWD ? W'(2) : W'(6));
    clear_taps(); ewe = 1'b0; owe = 1'b0; sa[2] = 7'd12;
    cycle();
    check("wb_tie_rc_even", rc_even, W'(6));

    // Stall freezes the loaded pair while addresses change
    for (int i = 0; i < 6; i++) sa[i] = 7'($urandom_range(0, 12));
    cycle();
    for (int i = 0; i < 6; i++) a[i] = m_out[i];
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 6; i++) sa[i] = 7'($urandom_range(0, 12));
      cycle();
      check("stall_ra_even", ra_even, a[0]);
      check("stall_rc_odd", rc_odd, a[5]);
    end
    stall = 1'b0; sa[0] = 7'd5;
    cycle();
    check("unstall_ra_even", ra_even, {4{32'hAAAAAAAA}});

    // Flush beats stall
    stall = 1'b1; flush = 1'b1;
    cycle();
    check("flush_valid", W'(operands_valid), '0);
    check("flush_ra_even", ra_even, '0);
    check("flush_rb_odd", rb_odd, '0);
    stall = 1'b0; flush = 1'b0;

    // Unused source ignores a matching live tap
    ofe[5] = 1'b1; ofa[5] = 7'd20; ofw[5] = rand128(); sa[5] = 7'd20; sv[5] = 1'b0;
    cycle();
    check("unused_rc_odd", rc_odd, '0);
    check("unused_valid", W'(operands_valid), W'(1));
    clear_taps(); sv[5] = 1'b1;

    // Reset wins over stall and flush
    reset = 1'b1; stall = 1'b1; flush = 1'b1;
    cycle();
    check("rst_over_stall_valid", W'(operands_valid), '0);
    reset = 1'b0;
    sa[0] = 7'd5;
    stall = 1'b0; flush = 1'b0;
    cycle();
    check("rst_clears_r5", ra_even, '0);

    // Randomized traffic over a small address range to provoke collisions
    for (int c = 0; c < 2000; c++) begin
      reset    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 6; i++) begin
        sa[i] = 7'($urandom_range(0, 15));
        sv[i] = ($urandom_range(0, 5) != 0);
      end
      for (int k = 0; k < D; k++) begin
        efe[k] = ($urandom_range(0, 2) == 0); efa[k] = 7'($urandom_range(0, 15)); efw[k] = rand128();
        ofe[k] = ($urandom_range(0, 2) == 0); ofa[k] = 7'($urandom_range(0, 15)); ofw[k] = rand128();
      end
      ewe = ($urandom_range(0, 1) == 1); era = 7'($urandom_range(0, 15)); ert = rand128();
      owe = ($urandom_range(0, 1) == 1); ora = 7'($urandom_range(0, 15)); ort = rand128();
      cycle();
    end

    clear_inputs();
    cycle(); cycle();
    #2;
    check("sb_queue_empty", W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
